// File: rtl/fifo_consumer.sv
// fifo_consumer: drains a sync FIFO into a single-port SRAM buffer,
// writing a descending address sequence in grant-arbitrated bursts.
module fifo_consumer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int BURST_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enb,
    output logic                  done,
    output logic                  request,
    input  logic                  grant,
    input  logic [ADDR_WIDTH-1:0] addr_begin,
    input  logic [ADDR_WIDTH-1:0] addr_nstep,
    input  logic [ADDR_WIDTH-1:0] addr_end,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  to_buffer_cs,
    output logic                  to_buffer_oe,
    output logic [ADDR_WIDTH-1:0] to_buffer_addr,
    input  logic [DATA_WIDTH-1:0] to_buffer_R_data,
    output logic                  to_buffer_W_req,
    output logic [DATA_WIDTH-1:0] to_buffer_W_data
);

    localparam int CW = $clog2(BURST_SIZE + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(BURST_SIZE);

    // SRAM control strobes are active-low
    localparam logic CS_ENB   = 1'b0;
    localparam logic CS_DIS   = 1'b1;
    localparam logic OE_DIS   = 1'b1;
    localparam logic WREQ_ENB = 1'b0;
    localparam logic WREQ_DIS = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pop_addr_q, pop_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
    logic                  pop_q, pop_d;
    logic                  last_q, last_d;
    logic                  pop;
    logic                  unused_rdata;

    assign unused_rdata = ^to_buffer_R_data;

    assign pop = (state_q == S_BURST) & grant & enb & ~fifo_empty
               & ~last_q & (pop_cnt_q < BURST_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            pop_addr_q <= '0;
            wr_addr_q  <= '0;
            pop_cnt_q  <= '0;
            pop_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pop_addr_q <= pop_addr_d;
            wr_addr_q  <= wr_addr_d;
            pop_cnt_q  <= pop_cnt_d;
            pop_q      <= pop_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (enb) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (enb & grant & ~fifo_empty & ~last_q) state_d = S_BURST;
            end
            S_BURST: begin
                // leave only once the last write has drained
                if (!pop && !pop_q) begin
                    if (pop_cnt_q == BURST_MAX) begin
                        state_d = last_q ? S_DONE : S_WAIT;
                    end else if (last_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop_addr_d = pop_addr_q;
        wr_addr_d  = wr_addr_q;
        pop_cnt_d  = pop_cnt_q;
        last_d     = last_q;
        pop_d      = pop;
        if (state_q == S_IDLE) begin
            pop_addr_d = addr_begin;
            wr_addr_d  = addr_begin;
            pop_cnt_d  = '0;
            last_d     = 1'b0;
        end else begin
            if (state_q == S_WAIT && state_d == S_BURST) begin
                pop_cnt_d = '0;
            end
            if (pop) begin
                pop_cnt_d  = pop_cnt_q + CW'(1);
                pop_addr_d = pop_addr_q - addr_nstep;
                if (pop_addr_q == addr_end) last_d = 1'b1;
            end
            if (pop_q) begin
                wr_addr_d = wr_addr_q - addr_nstep;
            end
        end
    end

    always_comb begin
        fifo_r_en      = pop;
        request        = enb & ((state_q == S_WAIT) | (state_q == S_BURST));
        done           = (state_q == S_DONE);
        to_buffer_oe   = OE_DIS;
        to_buffer_addr = wr_addr_q;
        if (pop_q) begin
            to_buffer_cs     = CS_ENB;
            to_buffer_W_req  = WREQ_ENB;
            to_buffer_W_data = fifo_data_out;
        end else begin
            to_buffer_cs     = CS_DIS;
            to_buffer_W_req  = WREQ_DIS;
            to_buffer_W_data = '0;
        end
    end

endmodule

// File: tb/tb_fifo_consumer.sv
// tb_fifo_consumer: FIFO + SRAM environment with an address-list
// reference model and a write scoreboard.
module tb_fifo_consumer;

    localparam int BS = 4;
    localparam logic CS_ENB   = 1'b0;
    localparam logic CS_DIS   = 1'b1;
    localparam logic OE_DIS   = 1'b1;
    localparam logic WREQ_ENB = 1'b0;
    localparam logic WREQ_DIS = 1'b1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enb;
    logic        done;
    logic        request;
    logic        grant;
    logic [19:0] addr_begin;
    logic [19:0] addr_nstep;
    logic [19:0] addr_end;
    logic        fifo_empty;
    logic        fifo_r_en;
    logic [15:0] fifo_data_out;
    logic        to_buffer_cs;
    logic        to_buffer_oe;
    logic [19:0] to_buffer_addr;
    logic [15:0] to_buffer_R_data;
    logic        to_buffer_W_req;
    logic [15:0] to_buffer_W_data;

    fifo_consumer #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(20),
        .BURST_SIZE(BS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enb(enb),
        .done(done),
        .request(request),
        .grant(grant),
        .addr_begin(addr_begin),
        .addr_nstep(addr_nstep),
        .addr_end(addr_end),
        .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en),
        .fifo_data_out(fifo_data_out),
        .to_buffer_cs(to_buffer_cs),
        .to_buffer_oe(to_buffer_oe),
        .to_buffer_addr(to_buffer_addr),
        .to_buffer_R_data(to_buffer_R_data),
        .to_buffer_W_req(to_buffer_W_req),
        .to_buffer_W_data(to_buffer_W_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    logic [15:0] fq[$];
    logic [15:0] pend[$];
    logic [15:0] words[$];
    logic [19:0] exp_addr[$];

    int  n_init;
    int  nw, widx, npops, ndone, nbursts, run;
    int  cyc_l, arr_pct, arr_hold, gmode, gdrop;
    bit  dropped, rd_prev, stop_enb, seen_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        bit prev;
        bit wr;
        @(posedge clk);
        #1;
        prev = rd_prev;
        if (prev && fq.size() > 0) fifo_data_out = fq.pop_front();
        cyc_l++;
        if (pend.size() > 0 && cyc_l >= arr_hold &&
            $urandom_range(99) < arr_pct) begin
            fq.push_back(pend.pop_front());
        end
        fifo_empty = (fq.size() == 0);
        if (stop_enb) enb = 1'b0;
        if (gmode == 1) begin
            grant = ($urandom_range(99) < 70);
        end else if (gmode == 2) begin
            if (!dropped && npops >= 2) begin
                dropped = 1'b1;
                gdrop = 3;
            end
            if (gdrop > 0) begin
                grant = 1'b0;
                gdrop--;
            end else begin
                grant = 1'b1;
            end
        end else begin
            grant = 1'b1;
        end
        #1;
        wr = (to_buffer_cs === CS_ENB);
        chk("wr_latency", {31'd0, wr}, {31'd0, prev});
        chk("wreq", {31'd0, to_buffer_W_req},
            {31'd0, prev ? WREQ_ENB : WREQ_DIS});
        chk("oe", {31'd0, to_buffer_oe}, {31'd0, OE_DIS});
        if (wr) begin
            chk("extra_write", {31'd0, widx < nw}, 32'd1);
            if (widx < nw) begin
                chk("wr_addr", {12'd0, to_buffer_addr}, {12'd0, exp_addr[widx]});
                chk("wr_data", {16'd0, to_buffer_W_data}, {16'd0, words[widx]});
            end
            widx++;
        end else begin
            chk("wdata_idle", {16'd0, to_buffer_W_data}, 32'd0);
        end
        if (fifo_r_en === 1'b1) begin
            chk("pop_nonempty", {31'd0, fifo_empty}, 32'd0);
            chk("pop_grant", {31'd0, grant}, 32'd1);
            chk("pop_request", {31'd0, request}, 32'd1);
            npops++;
            run++;
            if (!prev) nbursts++;
            chk("burst_len", {31'd0, run <= BS}, 32'd1);
        end else begin
            run = 0;
        end
        if (done === 1'b1) begin
            seen_done = 1'b1;
            ndone++;
            chk("done_after_last_wr", widx, nw);
            chk("done_request", {31'd0, request}, 32'd0);
            stop_enb = 1'b1;
        end
        rd_prev = (fifo_r_en === 1'b1);
    endtask

    task automatic setup(input logic [19:0] b, input logic [19:0] s,
                         input logic [19:0] e, input int npre,
                         input int nlate, input int pct, input int hold,
                         input int gm);
        logic [19:0] a;
        logic [15:0] w;
        exp_addr.delete();
        words.delete();
        fq.delete();
        pend.delete();
        a = b;
        exp_addr.push_back(a);
        while (a != e && exp_addr.size() < 64) begin
            a = a - s;
            exp_addr.push_back(a);
        end
        nw = exp_addr.size();
        for (int i = 0; i < npre + nlate; i++) begin
            w = 16'($urandom);
            words.push_back(w);
            if (i < npre) fq.push_back(w);
            else pend.push_back(w);
        end
        n_init = npre + nlate;
        widx = 0; npops = 0; ndone = 0; nbursts = 0; run = 0;
        cyc_l = 0; gdrop = 0; dropped = 1'b0;
        stop_enb = 1'b0; seen_done = 1'b0;
        arr_pct = pct; arr_hold = hold; gmode = gm;
        fifo_empty = (fq.size() == 0);
        addr_begin = b;
        addr_nstep = s;
        addr_end = e;
        grant = 1'b1;
        enb = 1'b1;
    endtask

    task automatic finish_xfer(input int exp_bursts);
        int budget;
        budget = 0;
        while (!seen_done && budget < 2000) begin
            step();
            budget++;
        end
        chk("done_timeout", {31'd0, seen_done}, 32'd1);
        repeat (3) step();
        chk("n_writes", widx, nw);
        chk("n_pops", npops, nw);
        chk("n_done", ndone, 1);
        chk("fifo_left", fq.size() + pend.size(), n_init - nw);
        if (exp_bursts >= 0) chk("n_bursts", nbursts, exp_bursts);
        enb = 1'b0;
        stop_enb = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_request"}, {31'd0, request}, 32'd0);
        chk({tag, "_r_en"}, {31'd0, fifo_r_en}, 32'd0);
        chk({tag, "_cs"}, {31'd0, to_buffer_cs}, {31'd0, CS_DIS});
        chk({tag, "_oe"}, {31'd0, to_buffer_oe}, {31'd0, OE_DIS});
        chk({tag, "_wreq"}, {31'd0, to_buffer_W_req}, {31'd0, WREQ_DIS});
        chk({tag, "_wdata"}, {16'd0, to_buffer_W_data}, 32'd0);
    endtask

    initial begin
        logic [19:0] rb, rs, re;
        int rn, rp;
        int b;
        rstn = 1'b0;
        enb = 1'b0;
        grant = 1'b0;
        addr_begin = '0;
        addr_nstep = '0;
        addr_end = '0;
        fifo_empty = 1'b1;
        fifo_data_out = '0;
        to_buffer_R_data = '0;
        rd_prev = 1'b0;
        gmode = 0; arr_pct = 0; arr_hold = 0; cyc_l = 0;
        #1;
        reset_outputs("rst");
        chk("rst_addr", {12'd0, to_buffer_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        setup(20'h10, 20'h1, 20'h09, 8, 0, 100, 0, 0);
        finish_xfer(2);

        setup(20'h20, 20'h2, 20'h1C, 5, 0, 100, 0, 0);
        finish_xfer(1);

        setup(20'h40, 20'h1, 20'h3C, 2, 3, 100, 8, 0);
        finish_xfer(-1);

        setup(20'h50, 20'h1, 20'h4A, 7, 0, 100, 0, 2);
        finish_xfer(-1);

        setup(20'h00001, 20'h1, 20'hFFFFF, 3, 1, 100, 0, 0);
        finish_xfer(1);

        for (int k = 0; k < 3; k++) begin
            rb = 20'($urandom);
            rs = 20'($urandom_range(1, 5));
            rn = $urandom_range(1, 11);
            re = rb - 20'(rn - 1) * rs;
            rp = $urandom_range(0, rn);
            setup(rb, rs, re, rp, rn - rp + $urandom_range(0, 2), 40, 0, 1);
            finish_xfer(-1);
        end

        setup(20'h90, 20'h3, 20'h90 - 20'd21, 8, 0, 100, 0, 0);
        b = 0;
        while (npops < 2 && b < 50) begin
            step();
            b++;
        end
        chk("rst_reach_burst", {31'd0, npops >= 2}, 32'd1);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        reset_outputs("arst");
        @(posedge clk);
        #1;
        reset_outputs("arst_hold");
        @(negedge clk);
        rstn = 1'b1;
        enb = 1'b0;
        rd_prev = 1'b0;

        setup(20'h90, 20'h3, 20'h90 - 20'd21, 8, 0, 100, 0, 0);
        finish_xfer(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_consumer.md
Name: fifo_consumer

Overview:
- Drains a synchronous FIFO and writes each popped word into a single-port SRAM buffer.
- Writes use a descending address sequence, from addr_begin down by addr_nstep until addr_end.
- This is the write-back counterpart of the buffer-to-FIFO producer. It sits between a sync FIFO's read side and an on-chip buffer, and shares the buffer through a request/grant arbiter.
- Moves words in bursts of up to BURST_SIZE and pulses done when the word for addr_end has been written.

Parameters:
DATA_WIDTH, 16, width of FIFO and SRAM data
ADDR_WIDTH, 20, SRAM address width
BURST_SIZE, 4, max words popped per grant burst (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enb  in  1  block enable; start and hold high for the whole transfer
done  out  1  one-cycle pulse, transfer complete
request  out  1  SRAM arbitration request
grant  in  1  SRAM ownership granted
addr_begin  in  ADDR_WIDTH  first write address
addr_nstep  in  ADDR_WIDTH  step subtracted per word
addr_end  in  ADDR_WIDTH  last write address
fifo_empty  in  1  FIFO empty flag
fifo_r_en  out  1  FIFO pop strobe
fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en
to_buffer_cs  out  1  SRAM chip select
to_buffer_oe  out  1  SRAM output enable
to_buffer_addr  out  ADDR_WIDTH  SRAM address
to_buffer_R_data  in  DATA_WIDTH  SRAM read data (unused)
to_buffer_W_req  out  1  SRAM write request
to_buffer_W_data  out  DATA_WIDTH  SRAM write data

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; pop_addr, wr_addr, pop_cnt, pop_q, last_q all 0.
  - Outputs: done=0, request=0, fifo_r_en=0, cs=CS_DIS, oe=OE_DIS, W_req=WREQ_DIS, W_data=0, addr=0.
  - Reset asserted mid-burst aborts immediately. A popped but unwritten word is lost; no recovery.
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - pop_addr<=addr_begin, wr_addr<=addr_begin, pop_cnt<=0, last_q<=0.
  - enb=1 -> WAIT.
- WAIT: enb & grant & ~fifo_empty & ~last_q -> BURST, pop_cnt<=0.
- BURST:
  - pop = grant & enb & ~fifo_empty & ~last_q & (pop_cnt<BURST_SIZE).
  - fifo_r_en=pop (combinational).
  - Each pop: pop_cnt++, pop_addr<=pop_addr-addr_nstep (mod 2^ADDR_WIDTH); if pop_addr==addr_end, last_q<=1.
  - pop_q<=pop.
- Write stage (any state): when pop_q=1:
  - cs=CS_ENB, W_req=WREQ_ENB, oe=OE_DIS.
  - to_buffer_addr=wr_addr, W_data=fifo_data_out.
  - wr_addr<=wr_addr-addr_nstep.
  - Otherwise cs=CS_DIS, W_req=WREQ_DIS, W_data=0, to_buffer_addr=wr_addr.
- Write latency: exactly 1 cycle after the pop.
- Grant contract: the arbiter keeps SRAM ownership for one cycle after grant falls, so a write in flight always completes.
- BURST exit: evaluated when pop_q=0 and no pop this cycle, and one of the following holds:
  - pop_cnt==BURST_SIZE: last_q ? DONE : WAIT.
  - last_q=1 (short final burst): DONE.
  - grant=0 or enb=0 with pop_cnt<BURST_SIZE: stay in BURST. Stalls on fifo_empty also stay in BURST.
- DONE: done=1 for one cycle -> IDLE.
- request = enb & (state==WAIT | state==BURST).
- Address arithmetic: subtraction wraps modulo 2^ADDR_WIDTH.
  - addr_begin==addr_end -> single-word transfer.
  - If addr_end is unreachable, the transfer never completes. Not checked in hardware.
- Inputs addr_begin, addr_nstep and addr_end must be stable from IDLE exit to done.
- No pop ever occurs when fifo_empty=1. No pop occurs after the addr_end word.

Test Plan:
- Basic transfer:
  - Stimulus: begin=0x10, nstep=1, end=0x09, BURST_SIZE=4; FIFO preloaded 8 words D0..D7; grant tied 1.
  - Required: two bursts; writes at 0x10..0x09 carry D0..D7, each 1 cycle after its fifo_r_en; single done pulse.
- Short final burst:
  - Stimulus: begin=0x20, nstep=2, end=0x1C.
  - Required: 3 writes at 0x20, 0x1E, 0x1C; no 4th pop; done after the 0x1C write.
- FIFO underflow stall:
  - Stimulus: FIFO holds 2 words at start; the third word arrives 5 cycles later.
  - Required: fifo_r_en stays 0 while empty; state remains BURST; addresses contiguous; no duplicate writes.
- Grant drop mid-burst:
  - Stimulus: grant falls after 2nd pop, returns 3 cycles later.
  - Required: 2nd word still written the cycle after grant falls; pops resume only with grant=1.
- Address wrap:
  - Stimulus: begin=0x00001, nstep=1, end=0xFFFFF (ADDR_WIDTH=20).
  - Required: writes at 0x00001, 0x00000, 0xFFFFF, then done.
- Async reset mid-burst:
  - Stimulus: rstn low between edges during BURST.
  - Required: outputs clear immediately without a clock edge (fifo_r_en=0, cs=CS_DIS, request=0); after release, state=IDLE and a new transfer restarts from addr_begin.
